// File: rtl/up_int_ctrl.sv
// Vectored interrupt controller for up_core: synchronised active-low request lines,
// per-channel mask and edge/level mode, fixed-priority arbitration, req/ack/eoi handshake.
module up_int_ctrl #(
    parameter int          N_INT       = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  VEC_BASE    = 8'hF0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_INT-1:0] irq_n,
    input  logic [1:0]       reg_addr,
    input  logic             reg_we,
    input  logic [7:0]       reg_wdata,
    output logic [7:0]       reg_rdata,
    output logic             int_req,
    output logic [7:0]       int_vec,
    input  logic             int_ack,
    input  logic             int_eoi
);

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_MODE = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    logic [N_INT-1:0] sync_r [SYNC_STAGES];
    logic [N_INT-1:0] synced_s;
    logic [N_INT-1:0] prev_r;
    logic [N_INT-1:0] fall_s;
    logic [N_INT-1:0] mask_r;
    logic [N_INT-1:0] mode_r;
    logic [N_INT-1:0] pend_r;
    logic [N_INT-1:0] pend_nxt_s;
    logic [N_INT-1:0] w1c_s;
    logic [N_INT-1:0] ack_clr_s;
    logic [N_INT-1:0] cand_s;
    logic             cand_any_s;
    logic [2:0]       cand_idx_s;
    logic             ack_take_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [2:0]       win_r;
    logic [2:0]       win_nxt_s;
    logic             int_req_nxt_s;
    logic [7:0]       int_vec_nxt_s;
    logic [7:0]       rdata_nxt_s;
    logic [2:0]       stat_idx_s;

    // Zero-extend a channel-wide register to the 8-bit read bus.
    function automatic logic [7:0] pad8(input logic [N_INT-1:0] v);
        logic [7:0] r;
        r = 8'h00;
        r[N_INT-1:0] = v;
        return r;
    endfunction

    // Synchroniser chain and previous-sample register for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= {N_INT{1'b1}};
            end
            prev_r <= {N_INT{1'b1}};
        end else begin
            sync_r[0] <= irq_n;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
            prev_r <= synced_s;
        end
    end

    assign synced_s   = sync_r[SYNC_STAGES-1];
    assign fall_s     = prev_r & ~synced_s;
    assign ack_take_s = (state_r == ST_REQ) && int_ack;
    assign cand_s     = pend_r & mask_r;
    assign cand_any_s = |cand_s;

    // Next pending value: edge channels set-dominant over W1C/ack clear, level channels follow the line.
    always_comb begin
        w1c_s      = {N_INT{1'b0}};
        ack_clr_s  = {N_INT{1'b0}};
        pend_nxt_s = pend_r;
        if (reg_we && (reg_addr == ADDR_PEND)) begin
            w1c_s = reg_wdata[N_INT-1:0];
        end else begin
            w1c_s = {N_INT{1'b0}};
        end
        for (int i = 0; i < N_INT; i++) begin
            ack_clr_s[i] = ack_take_s && (win_r == 3'(i));
            if (!mode_r[i]) begin
                pend_nxt_s[i] = ~synced_s[i];
            end else if (fall_s[i]) begin
                pend_nxt_s[i] = 1'b1;
            end else if (w1c_s[i] || ack_clr_s[i]) begin
                pend_nxt_s[i] = 1'b0;
            end else begin
                pend_nxt_s[i] = pend_r[i];
            end
        end
    end

    // Fixed priority: scanning downward leaves the lowest requesting index.
    always_comb begin
        cand_idx_s = 3'd0;
        for (int i = N_INT - 1; i >= 0; i--) begin
            if (cand_s[i]) begin
                cand_idx_s = 3'(i);
            end else begin
                cand_idx_s = cand_idx_s;
            end
        end
    end

    // Configuration, pending and registered read-data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_r    <= {N_INT{1'b0}};
            mode_r    <= {N_INT{1'b1}};
            pend_r    <= {N_INT{1'b0}};
            reg_rdata <= 8'h00;
        end else begin
            if (reg_we && (reg_addr == ADDR_MASK)) begin
                mask_r <= reg_wdata[N_INT-1:0];
            end
            if (reg_we && (reg_addr == ADDR_MODE)) begin
                mode_r <= reg_wdata[N_INT-1:0];
            end
            pend_r    <= pend_nxt_s;
            reg_rdata <= rdata_nxt_s;
        end
    end

    // Read mux; the STAT index field only reports a grant while one is open.
    always_comb begin
        rdata_nxt_s = 8'h00;
        if (state_r != ST_IDLE) begin
            stat_idx_s = win_r;
        end else begin
            stat_idx_s = 3'd0;
        end
        case (reg_addr)
            ADDR_MASK: rdata_nxt_s = pad8(mask_r);
            ADDR_MODE: rdata_nxt_s = pad8(mode_r);
            ADDR_PEND: rdata_nxt_s = pad8(pend_r);
            ADDR_STAT: rdata_nxt_s = {(state_r == ST_SERVICE), int_req, 3'b000, stat_idx_s};
            default:   rdata_nxt_s = 8'h00;
        endcase
    end

    // Handshake FSM state and registered request outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            win_r   <= 3'd0;
            int_req <= 1'b0;
            int_vec <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            win_r   <= win_nxt_s;
            int_req <= int_req_nxt_s;
            int_vec <= int_vec_nxt_s;
        end
    end

    // Next-state: a grant is committed in REQ until acked; no nesting in SERVICE.
    always_comb begin
        state_nxt_s   = state_r;
        win_nxt_s     = win_r;
        int_req_nxt_s = int_req;
        int_vec_nxt_s = int_vec;
        case (state_r)
            ST_IDLE: begin
                if (cand_any_s) begin
                    state_nxt_s   = ST_REQ;
                    win_nxt_s     = cand_idx_s;
                    int_req_nxt_s = 1'b1;
                    int_vec_nxt_s = VEC_BASE + {5'b00000, cand_idx_s};
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_nxt_s   = ST_SERVICE;
                    int_req_nxt_s = 1'b0;
                end else begin
                    state_nxt_s   = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (int_eoi) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SERVICE;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                int_req_nxt_s = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_up_int_ctrl.sv
// Directed bench for up_int_ctrl: expectations are queued as stimulus is applied and
// compared against the DUT outputs when they become due.
module tb_up_int_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] irq_n;
    logic [1:0] reg_addr;
    logic       reg_we;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       int_req;
    logic [7:0] int_vec;
    logic       int_ack;
    logic       int_eoi;

    up_int_ctrl #(.N_INT(8), .SYNC_STAGES(2), .VEC_BASE(8'hF0)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_n    (irq_n),
        .reg_addr (reg_addr),
        .reg_we   (reg_we),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .int_req  (int_req),
        .int_vec  (int_vec),
        .int_ack  (int_ack),
        .int_eoi  (int_eoi)
    );

    localparam logic [1:0] A_MASK = 2'd0;
    localparam logic [1:0] A_MODE = 2'd1;
    localparam logic [1:0] A_PEND = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic push_exp(input string tag, input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [7:0] obs);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h expected queued entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
        end
    endtask

    task automatic check_io(input string tag, input logic exp_req, input logic [7:0] exp_vec);
        push_exp({tag, "_req"}, {7'b0000000, exp_req});
        pop_cmp({7'b0000000, int_req});
        push_exp({tag, "_vec"}, exp_vec);
        pop_cmp(int_vec);
    endtask

    task automatic check_req(input string tag, input logic exp_req);
        push_exp({tag, "_req"}, {7'b0000000, exp_req});
        pop_cmp({7'b0000000, int_req});
    endtask

    task automatic read_reg(input logic [1:0] addr, input logic [7:0] exp, input string tag);
        reg_addr = addr;
        push_exp(tag, exp);
        tick();
        pop_cmp(reg_rdata);
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [7:0] data);
        reg_addr  = addr;
        reg_wdata = data;
        reg_we    = 1'b1;
        tick();
        reg_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        irq_n     = 8'hFF;
        reg_addr  = 2'd0;
        reg_we    = 1'b0;
        reg_wdata = 8'h00;
        int_ack   = 1'b0;
        int_eoi   = 1'b0;
        ticks(2);
        rst = 1'b0;
        tick();
        check_io("reset_out", 1'b0, 8'h00);

        // Single edge channel through the full handshake, with latency boundary.
        write_reg(A_MASK, 8'h08);
        irq_n[3] = 1'b0;
        ticks(3);
        check_req("t2_edge3", 1'b0);
        tick();
        check_io("t2_edge4", 1'b1, 8'hF3);
        read_reg(A_STAT, 8'h43, "t2_stat_req");
        pulse_ack();
        check_io("t2_after_ack", 1'b0, 8'hF3);
        read_reg(A_PEND, 8'h00, "t2_pend");
        read_reg(A_STAT, 8'h83, "t2_stat_svc");
        irq_n[3] = 1'b1;
        pulse_eoi();
        read_reg(A_STAT, 8'h00, "t2_stat_idle");

        // Reset asserted with a request open.
        write_reg(A_MASK, 8'hFF);
        irq_n[4] = 1'b0;
        ticks(4);
        check_io("t1_pre_rst", 1'b1, 8'hF4);
        rst = 1'b1;
        #1;
        check_io("t1_in_rst", 1'b0, 8'h00);
        irq_n = 8'hFF;
        tick();
        rst = 1'b0;
        read_reg(A_MASK, 8'h00, "t1_mask");
        read_reg(A_MODE, 8'hFF, "t1_mode");
        read_reg(A_PEND, 8'h00, "t1_pend");
        read_reg(A_STAT, 8'h00, "t1_stat");

        // Two simultaneous edges: lowest index first, the other follows without a new edge.
        write_reg(A_MASK, 8'hFF);
        irq_n[5] = 1'b0;
        irq_n[1] = 1'b0;
        ticks(4);
        check_io("t3_first", 1'b1, 8'hF1);
        pulse_ack();
        irq_n = 8'hFF;
        read_reg(A_PEND, 8'h20, "t3_pend_svc");
        pulse_eoi();
        tick();
        check_io("t3_second", 1'b1, 8'hF5);
        pulse_ack();
        pulse_eoi();
        read_reg(A_PEND, 8'h00, "t3_pend_done");

        // Masked channel still records PEND; unmasking requests one edge later.
        write_reg(A_MASK, 8'h00);
        irq_n[0] = 1'b0;
        ticks(4);
        check_req("t4_masked", 1'b0);
        read_reg(A_PEND, 8'h01, "t4_pend");
        write_reg(A_MASK, 8'h01);
        check_req("t4_write_edge", 1'b0);
        tick();
        check_io("t4_unmasked", 1'b1, 8'hF0);
        pulse_ack();
        irq_n[0] = 1'b1;
        pulse_eoi();

        // Level mode: re-request while held low, W1C ignored, clears when line rises.
        write_reg(A_MODE, 8'h00);
        write_reg(A_MASK, 8'h04);
        irq_n[2] = 1'b0;
        ticks(4);
        check_io("t5_first", 1'b1, 8'hF2);
        pulse_ack();
        check_req("t5_svc", 1'b0);
        pulse_eoi();
        tick();
        check_io("t5_rereq", 1'b1, 8'hF2);
        pulse_ack();
        write_reg(A_PEND, 8'h04);
        read_reg(A_PEND, 8'h04, "t5_pend_w1c_ignored");
        irq_n[2] = 1'b1;
        ticks(3);
        read_reg(A_PEND, 8'h00, "t5_pend_released");
        pulse_eoi();
        tick();
        check_req("t5_no_rereq", 1'b0);
        read_reg(A_STAT, 8'h00, "t5_stat");

        // Edge and W1C on the same edge: set wins; ack+eoi together only acks.
        write_reg(A_MODE, 8'hFF);
        write_reg(A_MASK, 8'h40);
        irq_n[6] = 1'b0;
        ticks(2);
        write_reg(A_PEND, 8'h40);
        read_reg(A_PEND, 8'h40, "t6_set_wins");
        check_io("t6_req", 1'b1, 8'hF6);
        int_ack = 1'b1;
        int_eoi = 1'b1;
        tick();
        int_ack = 1'b0;
        int_eoi = 1'b0;
        read_reg(A_PEND, 8'h00, "t6_pend_acked");
        read_reg(A_STAT, 8'h86, "t6_stat_svc");
        irq_n[6] = 1'b1;
        pulse_eoi();
        read_reg(A_STAT, 8'h00, "t6_stat_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
